adventure_room_ctrl: RTL

Room-navigation controller for the adventure game. It accepts player moves through a valid/ready handshake, walks the room map, and pulses the sword-found strobe into the sword-tracking FSM. It reads back the tracker's has-sword flag to resolve the dragon encounter, and owns the move counter and game-over conditions.

---
 rtl/adventure_room_ctrl.sv | 131 +++++++++++++
 1 files changed

// File: rtl/adventure_room_ctrl.sv
// adventure_room_ctrl: room-navigation controller with move handshake,
// sword-found strobe, timed dragon encounter and move budget.
`default_nettype none

module adventure_room_ctrl #(
  parameter int MAX_MOVES  = 32,
  parameter int CNT_W      = 8,
  parameter int DRAGON_DLY = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             move_valid,
  input  logic [1:0]       move_dir,
  output logic             move_ready,
  input  logic             has_sword,
  output logic             sw,
  output logic [2:0]       room,
  output logic             illegal,
  output logic [CNT_W-1:0] move_count,
  output logic             win,
  output logic             dead
);

  localparam int TMR_W = (DRAGON_DLY > 1) ? $clog2(DRAGON_DLY) : 1;
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_MOVES);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(DRAGON_DLY - 1);

  localparam logic [1:0] DIR_N = 2'b00;
  localparam logic [1:0] DIR_S = 2'b01;
  localparam logic [1:0] DIR_E = 2'b10;
  localparam logic [1:0] DIR_W = 2'b11;

  typedef enum logic [2:0] {
    CAVE   = 3'd0,
    TUNNEL = 3'd1,
    RIVER  = 3'd2,
    STASH  = 3'd3,
    DRAGON = 3'd4,
    VAULT  = 3'd5,
    GRAVE  = 3'd6
  } room_t;

  room_t            room_q;
  room_t            exit_room;
  logic             exit_ok;
  logic             roaming;
  logic             accept;
  logic [TMR_W-1:0] timer;

  assign roaming    = (room_q == CAVE) || (room_q == TUNNEL) ||
                      (room_q == RIVER) || (room_q == STASH);
  assign move_ready = roaming && (move_count != MAX_CNT);
  assign accept     = move_valid && move_ready;

  assign room = room_q;
  assign win  = (room_q == VAULT);
  assign dead = (room_q == GRAVE);

  // Room map: the destination for the requested direction, if an exit exists.
  always_comb begin
    exit_room = room_q;
    exit_ok   = 1'b0;
    case (room_q)
      CAVE: begin
        if (move_dir == DIR_E) begin exit_room = TUNNEL; exit_ok = 1'b1; end
      end
      TUNNEL: begin
        if (move_dir == DIR_W) begin exit_room = CAVE;  exit_ok = 1'b1; end
        if (move_dir == DIR_S) begin exit_room = RIVER; exit_ok = 1'b1; end
      end
      RIVER: begin
        if (move_dir == DIR_N) begin exit_room = TUNNEL; exit_ok = 1'b1; end
        if (move_dir == DIR_W) begin exit_room = STASH;  exit_ok = 1'b1; end
        if (move_dir == DIR_E) begin exit_room = DRAGON; exit_ok = 1'b1; end
      end
      STASH: begin
        if (move_dir == DIR_E) begin exit_room = RIVER; exit_ok = 1'b1; end
      end
      default: begin
        exit_room = room_q;
        exit_ok   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      room_q     <= CAVE;
      move_count <= '0;
      timer      <= '0;
      sw         <= 1'b0;
      illegal    <= 1'b0;
    end else begin
      sw      <= 1'b0;
      illegal <= 1'b0;
      case (room_q)
        CAVE, TUNNEL, RIVER, STASH: begin
          if (accept) begin
            move_count <= move_count + 1'b1;
            if (exit_ok) begin
              room_q <= exit_room;
              sw     <= (exit_room == STASH);
              timer  <= '0;
            end else begin
              illegal <= 1'b1;
            end
          end else if (move_count == MAX_CNT) begin
            room_q <= GRAVE;
          end
        end
        // The move budget is not checked here, so a last-slot entry still fights.
        DRAGON: begin
          if (timer == TMR_LAST) begin
            room_q <= has_sword ? VAULT : GRAVE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        VAULT, GRAVE: begin
          room_q <= room_q;
        end
        default: begin
          room_q <= CAVE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
